// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter: state encoding,
// accumulator sizing and digit limits.
package bcd2bin_seq_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_CONV = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;

    // Bits needed to hold any N-digit decimal value: ceil(log2(10^n_digits)).
    function automatic int calc_acc_w(input int n_digits);
        longint unsigned limit;
        int              w;
        limit = 1;
        for (int i = 0; i < n_digits; i++) begin
            limit = limit * 10;
        end
        w = 0;
        while ((longint'(1) << w) < limit) begin
            w++;
        end
        return w;
    endfunction

    function automatic logic digit_invalid(input logic [3:0] digit);
        return digit > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_bcd_sub3.sv
// Reverse double-dabble digit corrector: after a right shift, a BCD nibble
// holding 8 or more gets 3 subtracted (inverse of the add-3 cell).
module bcd_sub3
    import bcd2bin_seq_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    assign corrected = (nibble >= CORR_THRESH) ? nibble - CORR_SUB : nibble;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, one
// shift-and-correct step per clock under a start/busy/done handshake.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 11,
    parameter int ACC_W    = calc_acc_w(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int SR_W  = BCD_W + ACC_W;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int CMP_W = ((ACC_W > BIN_W) ? ACC_W : BIN_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);
    localparam logic [CMP_W-1:0] BIN_MAX  = {{(CMP_W - BIN_W){1'b0}}, {BIN_W{1'b1}}};

    logic [ST_W-1:0]  state;
    logic [BCD_W-1:0] bcd_reg;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             in_invalid;
    logic [SR_W-1:0]  shifted;
    logic [BCD_W-1:0] bcd_next;
    logic [ACC_W-1:0] acc_next;
    logic [CMP_W-1:0] acc_ext;
    logic             res_ovf;
    logic [BIN_W-1:0] res_bin;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_invalid = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_invalid(bcd_in[4*i +: 4])) begin
                in_invalid = 1'b1;
            end
        end
    end

    // The BCD digits and the accumulator shift as one register; bits leave the
    // BCD side LSB-first and collect at the top of the accumulator.
    assign shifted  = {bcd_reg, acc} >> 1;
    assign acc_next = shifted[ACC_W-1:0];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_sub3 u_sub3 (
            .nibble    (shifted[ACC_W + 4*g +: 4]),
            .corrected (bcd_next[4*g +: 4])
        );
    end

    // Result of the final step, saturated to the output width.
    assign acc_ext = CMP_W'(acc_next);
    assign res_ovf = acc_ext > BIN_MAX;
    assign res_bin = res_ovf ? {BIN_W{1'b1}} : acc_ext[BIN_W-1:0];

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bcd_reg <= '0;
            acc     <= '0;
            cnt     <= '0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bcd_reg <= bcd_in;
                        acc     <= '0;
                        cnt     <= '0;
                        if (in_invalid) begin
                            state   <= ST_DONE;
                            bin_out <= '0;
                            ovf     <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            state <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    bcd_reg <= bcd_next;
                    acc     <= acc_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        bin_out <= res_bin;
                        ovf     <= res_ovf;
                        err     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD path.
- Takes N_DIGITS packed BCD digits, such as a value keyed in on switches or a 4-digit display entry, and produces an unsigned binary value of BIN_W bits.
- Uses reverse double dabble: one shift-right-and-correct step per clock, under a start/busy/done handshake.
- Sits between user-entry/BCD sources and arithmetic datapaths that need binary operands.

Parameters:
- N_DIGITS, 4, number of packed BCD input digits (4 bits each).
- BIN_W, 11, width of the binary result.
- ACC_W, 14, internal shift/iteration count = ceil(log2(10^N_DIGITS)); 14 for N_DIGITS=4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a conversion; sampled only when busy=0.
- bcd_in  in  4*N_DIGITS  packed BCD; digit 0 in [3:0].
- busy  out  1  high from the start-accept edge until done deasserts.
- done  out  1  one-cycle completion pulse.
- bin_out  out  BIN_W  result; holds until the next done.
- ovf  out  1  value exceeded 2^BIN_W-1; valid with done, held with bin_out.
- err  out  1  a nibble of bcd_in was >9; valid with done, held with bin_out.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, bin_out=0, ovf=0, err=0, internal registers 0.
- Reset mid-conversion aborts immediately to these values; no done is produced.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at edge k:
  - Register bcd_in; clear the binary accumulator (ACC_W bits); cnt=0; busy=1.
  - If any nibble >9: go to DONE. done=1, err=1, ovf=0, bin_out=0, all visible the cycle after edge k (latency 1).
  - Otherwise go to CONV.
- CONV, each edge:
  - Shift {bcd_reg, acc} right by 1 as one concatenated register.
  - Then each BCD nibble that is >=8 after the shift has 3 subtracted.
  - cnt increments by 1.
  - On the ACC_W-th step (edge k+ACC_W): go to DONE; load results; done=1.
- Result rules:
  - If acc > 2^BIN_W-1: ovf=1 and bin_out saturates to all ones (2047).
  - Else ovf=0 and bin_out = acc[BIN_W-1:0].
  - err=0.
- Latency: done is high in the cycle after edge k+14 for N_DIGITS=4.
- DONE: lasts one cycle. Next edge: done=0, busy=0, state=IDLE. A start that is high during DONE is ignored.
- Earliest next acceptance is the edge after busy falls.
- start while busy=1 is ignored; no queuing. bcd_in changes after acceptance have no effect.
- start held high continuously produces back-to-back conversions, one per ACC_W+2 cycles.
- bin_out, ovf and err change only on the done edge or on reset.

Decomposition:
- Shared package holds:
  - State encoding constants for IDLE/CONV/DONE.
  - Function computing ACC_W from N_DIGITS.
  - Constant DIGIT_MAX=9.
- Natural sub-module: bcd_sub3, a combinational 4-bit corrector (out = in>=8 ? in-3 : in).
  - It mirrors the existing add3 cell.
  - Instantiated N_DIGITS times in a generate loop on the shifted BCD register.

Test Plan:
- Reset, then bcd_in=16'h1999, start pulse -> busy=1; done exactly 14 cycles after the accept edge; bin_out=11'h7CF (1999); ovf=0; err=0.
- bcd_in=16'h2047 -> bin_out=11'h7FF, ovf=0. Then bcd_in=16'h2048 -> bin_out=11'h7FF, ovf=1. Then 16'h9999 -> ovf=1.
- bcd_in=16'h12A4 -> done 1 cycle after accept; err=1; bin_out=0; ovf=0. Follow with 16'h0000 -> bin_out=0, err=0.
- start pulsed again at cycle 5 of a conversion, and bcd_in changed mid-conversion -> single done; result matches the originally latched input; no second conversion.
- rst_n asserted asynchronously (between clock edges) mid-CONV -> busy/done/bin_out/ovf/err go to 0 immediately; no done after release; next start converts 16'h0042 -> 42 correctly.
- start held high with bcd_in=16'h0001 -> done pulses every 16 cycles; bin_out=1 each time; done never high two consecutive cycles.
